// File: rtl/one_pulser_pkg.sv
// Shared types and default parameters for the push-button one-pulser.
package one_pulser_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PULSE        = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_e;

    localparam int unsigned SyncStagesDef     = 2;
    localparam int unsigned DebounceCyclesDef = 0;
    localparam int unsigned CntWDef           = 16;

endpackage

// File: rtl/btn_conditioner.sv
// Synchronises a raw asynchronous button level and optionally debounces it.
module btn_conditioner
    import one_pulser_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SyncStagesDef,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
    parameter int unsigned CNT_W           = CntWDef
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_pass
        assign level = btn_s;
    end else begin : g_deb
        localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
        localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d;

        // Counter only runs while the synchronised level disagrees with the filtered one.
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (btn_s != lvl_q) begin
                if (cnt_q == CntLast) begin
                    lvl_d = btn_s;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign level = lvl_q;
    end

endmodule

// File: rtl/one_pulser.sv
// Turns each button press into exactly one registered single-cycle pulse.
module one_pulser
    import one_pulser_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SyncStagesDef,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
    parameter int unsigned CNT_W           = CntWDef
) (
    input  logic clk,
    input  logic rst,
    input  logic btnIn,
    output logic pulser
);

    logic   btn_f;
    state_e state_q, state_d;
    logic   pulser_q;

    btn_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_cond (
        .clk  (clk),
        .rst  (rst),
        .raw  (btnIn),
        .level(btn_f)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:         if (btn_f) state_d = PULSE;
            PULSE:        state_d = btn_f ? WAIT_RELEASE : IDLE;
            WAIT_RELEASE: if (!btn_f) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Output is registered from the next state so it is high exactly while in PULSE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pulser_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pulser_q <= (state_d == PULSE);
        end
    end

    assign pulser = pulser_q;

endmodule

// File: tb/tb_one_pulser.sv
// Bench for one_pulser: a pass-through instance and a 4-cycle debounce instance.
module tb_one_pulser;

    localparam int unsigned Sync = 2;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic btnIn = 1'b0;
    logic p0, p1;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cnt0, cnt1, first0, first1;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    one_pulser #(
        .SYNC_STAGES    (Sync),
        .DEBOUNCE_CYCLES(0),
        .CNT_W          (16)
    ) dut0 (
        .clk   (clk),
        .rst   (rst),
        .btnIn (btnIn),
        .pulser(p0)
    );

    one_pulser #(
        .SYNC_STAGES    (Sync),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut1 (
        .clk   (clk),
        .rst   (rst),
        .btnIn (btnIn),
        .pulser(p1)
    );

    always #5 clk = ~clk;

    // Reference: btn_s is btnIn delayed by Sync-1 samples; the filtered level adopts btn_s
    // once they have disagreed for D consecutive samples; a pulse follows each rise of it.
    logic [3:0] m_sh[2];
    logic       m_s[2], m_f[2], m_fp[2], m_exp[2];
    int         m_run[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_sh[i] = '0; m_s[i] = 1'b0; m_f[i] = 1'b0; m_fp[i] = 1'b0;
            m_exp[i] = 1'b0; m_run[i] = 0;
        end
    end

    always @(posedge clk or negedge rst) begin
        logic np, s_old;
        int   d;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_sh[i] = '0; m_s[i] = 1'b0; m_f[i] = 1'b0; m_fp[i] = 1'b0;
                m_exp[i] = 1'b0; m_run[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                d       = (i == 0) ? 0 : 4;
                np      = m_f[i] & ~m_fp[i];
                s_old   = m_s[i];
                m_s[i]  = m_sh[i][Sync-2];
                m_sh[i] = {m_sh[i][2:0], btnIn};
                m_fp[i] = m_f[i];
                if (d == 0) begin
                    m_f[i] = m_s[i];
                end else if (s_old != m_f[i]) begin
                    m_run[i]++;
                    if (m_run[i] == d) begin
                        m_f[i]   = s_old;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_exp[i] = np;
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("pulser_d0", p0, m_exp[0]);
        chk("pulser_d4", p1, m_exp[1]);
        chk("no_double_d0", p0 & prev0, 1'b0);
        chk("no_double_d4", p1 & prev1, 1'b0);
        prev0 = p0;
        prev1 = p1;
        cnt0 += int'(p0);
        cnt1 += int'(p1);
    endtask

    task automatic press(input int hi, input int total);
        cnt0 = 0; cnt1 = 0; first0 = 0; first1 = 0;
        btnIn = 1'b1;
        for (int t = 1; t <= total; t++) begin
            tick();
            if (p0 && first0 == 0) first0 = t;
            if (p1 && first1 == 0) first1 = t;
            if (t == hi) btnIn = 1'b0;
        end
    endtask

    initial begin
        int tot0, found, len;

        // Reset held with button pressed
        #1 rst = 1'b0;
        btnIn = 1'b1;
        repeat (3) begin
            tick();
            chk("reset_d0", p0, 1'b0);
        end
        btnIn = 1'b0;
        rst   = 1'b1;
        cnt0 = 0;
        repeat (5) tick();
        chk_int("post_reset_cnt", cnt0, 0);

        // Two single-cycle presses
        press(1, 28);
        chk_int("short_lat", first0, 3);
        chk_int("short_cnt", cnt0, 1);
        chk_int("short_d4_cnt", cnt1, 0);
        tot0 = cnt0;
        press(1, 28);
        chk_int("second_lat", first0, 3);
        tot0 += cnt0;
        chk_int("two_press_total", tot0, 2);

        // Long hold, then release and re-press
        press(40, 48);
        chk_int("long_lat", first0, 3);
        chk_int("long_cnt", cnt0, 1);
        chk_int("long_d4_lat", first1, 7);
        chk_int("long_d4_cnt", cnt1, 1);
        press(5, 12);
        chk_int("repress_cnt", cnt0, 1);
        chk_int("repress_d4_cnt", cnt1, 1);
        repeat (10) tick();

        // Toggle every cycle: debounced instance must stay silent
        cnt0 = 0; cnt1 = 0;
        for (int t = 0; t < 10; t++) begin
            btnIn = (t % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        btnIn = 1'b0;
        repeat (4) tick();
        chk_int("toggle_d0_cnt", cnt0, 5);
        chk_int("toggle_d4_cnt", cnt1, 0);
        press(20, 30);
        chk_int("stable_d4_lat", first1, 7);
        chk_int("stable_d4_cnt", cnt1, 1);
        repeat (5) tick();

        // Asynchronous reset while pulser is high, button still held
        btnIn = 1'b1;
        found = 0;
        for (int t = 0; t < 10 && found == 0; t++) begin
            tick();
            if (p0) found = 1;
        end
        chk_int("rst_wait_pulse", found, 1);
        #2 rst = 1'b0;
        #1 chk("rst_async_drop", p0, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        cnt0 = 0; cnt1 = 0;
        repeat (12) tick();
        chk_int("rst_repulse_d0", cnt0, 1);
        chk_int("rst_repulse_d4", cnt1, 1);

        // Random press/release segments
        btnIn = 1'b0;
        repeat (10) tick();
        for (int s = 0; s < 60; s++) begin
            btnIn = 1'($urandom_range(0, 1));
            len   = int'($urandom_range(1, 8));
            repeat (len) tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
